scope_capture: RTL and testbench
================================

SCOPE_CAPTURE -- requirements
Module: scope_capture

Interface
REQ-001 Parameter DEPTH, default 256, is the capture buffer depth in samples and SHALL be a power of two.
REQ-002 Parameter PRE_TRIG, default 64, is the number of pre-trigger samples and SHALL satisfy 1 <= PRE_TRIG < DEPTH.
REQ-003 clk  in  1  the single clock; all logic SHALL be on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 sample_in  in  8  unsigned waveform sample from the function generator.
REQ-006 sample_valid  in  1  sample_in is valid this cycle.
REQ-007 arm  in  1  single-cycle request to start a capture.
REQ-008 abort  in  1  cancels any capture or readout.
REQ-009 force_trig  in  1  forces a trigger while waiting for one.
REQ-010 trig_level  in  8  trigger threshold.
REQ-011 trig_slope  in  1  trigger edge: 0 = rising, 1 = falling.
REQ-012 out_data  out  8  readout sample.
REQ-013 out_valid  out  1  out_data is valid.
REQ-014 out_ready  in  1  the consumer accepts out_data.
REQ-015 out_last  out  1  marks the final sample of the readout.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 triggered  out  1  a trigger has occurred in the current capture.
REQ-018 done  out  1  one-cycle pulse when the readout completes.

Function
REQ-019 The FSM SHALL have the states IDLE, PRE_FILL, WAIT_TRIG, POST_FILL and READOUT.
REQ-020 IDLE: on arm=1, go to PRE_FILL, clear wr_ptr, the sample count and triggered; arm outside IDLE SHALL be ignored.
REQ-021 PRE_FILL, WAIT_TRIG, POST_FILL: each sample_valid=1 cycle SHALL write sample_in to mem[wr_ptr], then wr_ptr = (wr_ptr+1) mod DEPTH.
REQ-022 sample_valid SHALL be ignored in IDLE and READOUT.
REQ-023 PRE_FILL SHALL go to WAIT_TRIG on the cycle the PRE_TRIG-th sample is written.
REQ-024 Rising trigger (WAIT_TRIG only): a valid sample with prev < trig_level and sample_in >= trig_level.
REQ-025 Falling trigger (WAIT_TRIG only): a valid sample with prev > trig_level and sample_in <= trig_level.
REQ-026 prev is the last valid sample written since arm; the first sample after arm can never trigger.
REQ-027 force_trig=1 in WAIT_TRIG SHALL make the next valid sample the trigger, regardless of level.
REQ-028 The trigger sample SHALL be written, latch trig_addr = its write address, set triggered=1, count as post-sample 1, and move the FSM to POST_FILL.
REQ-029 In WAIT_TRIG, wr_ptr SHALL keep wrapping, so the buffer always holds the newest samples.
REQ-030 POST_FILL SHALL go to READOUT on the cycle the (DEPTH-PRE_TRIG)-th post-sample, counting the trigger sample, is written.
REQ-031 READOUT SHALL emit DEPTH samples starting at address (trig_addr - PRE_TRIG) mod DEPTH, with the address incrementing mod DEPTH.
REQ-032 The trigger sample SHALL therefore be readout index PRE_TRIG.
REQ-033 out_valid SHALL first assert exactly 1 cycle after READOUT entry (synchronous RAM read).
REQ-034 A transfer occurs when out_valid=1 and out_ready=1.
REQ-035 While out_valid=1 and out_ready=0, out_data and out_last SHALL remain stable.
REQ-036 A continuously ready consumer SHALL receive one sample per cycle with no bubbles.
REQ-037 out_last SHALL be 1 only with the DEPTH-th sample.
REQ-038 After the last transfer, the block SHALL go to IDLE, drop out_valid and pulse done for 1 cycle.
REQ-039 abort=1 in any state SHALL return the FSM to IDLE on the next edge, with out_valid, out_last and triggered cleared and no done pulse; abort has priority over arm.

Reset
REQ-040 reset=0 SHALL immediately force state=IDLE, wr_ptr=0, counters=0, out_data=0, out_valid=0, out_last=0, busy=0, triggered=0 and done=0.
REQ-041 Memory contents SHALL NOT be reset.
REQ-042 Reset asserted mid-capture or mid-readout SHALL discard that operation.

Structure
REQ-043 Package scope_pkg SHALL hold the FSM state enum, the slope encoding constants and the DEPTH/PRE_TRIG defaults.
REQ-044 Sub-module scope_sample_ram SHALL be a simple dual-port RAM (one write port, one synchronous-read port), 8 bits x DEPTH.

Verification
REQ-045 Ramp 0..255 repeating, level=128, rising slope, out_ready=1 -> 256 samples; index 64 = 128; index 0 = 64; out_last on index 255; done pulse.
REQ-046 Same ramp with falling slope, level=10 -> trigger at the 255->0 wrap sample; index 64 = 0; index 63 = 255.
REQ-047 Constant 50, level=128, force_trig pulsed after 100 samples -> triggered=1; all 256 readout samples = 50.
REQ-048 Readout with out_ready toggling 1-0-0-1 -> out_data held during stalls; exactly 256 transfers; ordering unchanged.
REQ-049 abort during POST_FILL, then abort during READOUT -> IDLE next cycle; out_valid=0; no done pulse; a new arm captures correctly.
REQ-050 reset=0 mid-WAIT_TRIG -> all outputs 0 immediately; arm ignored while reset=0.

Source files
------------

// File: rtl/scope_pkg.sv
// Shared types and defaults for the scope capture block.
// FSM encoding, trigger slope codes and buffer geometry.
package scope_pkg;

  localparam int DEPTH_DEF    = 256;
  localparam int PRE_TRIG_DEF = 64;

  localparam logic SLOPE_RISE = 1'b0;
  localparam logic SLOPE_FALL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    PRE_FILL,
    WAIT_TRIG,
    POST_FILL,
    READOUT
  } state_t;

endpackage

// File: rtl/scope_capture_if.sv
// Sample input stream and readout valid/ready stream.
// The capture block sits on the master side.
interface scope_capture_if;

  logic [7:0] sample_in;
  logic       sample_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (
    input  sample_in,
    input  sample_valid,
    input  out_ready,
    output out_data,
    output out_valid,
    output out_last
  );

  modport slave (
    output sample_in,
    output sample_valid,
    output out_ready,
    input  out_data,
    input  out_valid,
    input  out_last
  );

endinterface

// File: rtl/scope_sample_ram.sv
// Simple dual-port sample buffer: one write port,
// one synchronous read port with a held output register.
module scope_sample_ram #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [7:0]               wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [7:0]               rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the read register is reset; it holds while re=0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/scope_capture.sv
// Triggered waveform capture with pre/post-trigger windows
// and a valid/ready readout of the whole buffer.
module scope_capture
  import scope_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int PRE_TRIG = PRE_TRIG_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  scope_capture_if.master        bus,
  input  logic                   arm,
  input  logic                   abort,
  input  logic                   force_trig,
  input  logic [7:0]             trig_level,
  input  logic                   trig_slope,
  output logic                   busy,
  output logic                   triggered,
  output logic                   done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] PRE_N  = CW'(PRE_TRIG);
  localparam logic [CW-1:0] POST_N = CW'(DEPTH - PRE_TRIG);
  localparam logic [CW-1:0] ALL_N  = CW'(DEPTH);
  localparam logic [AW-1:0] PRE_OF = AW'(PRE_TRIG);

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] trig_addr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] rd_cnt;
  logic [7:0]    prev;
  logic          have_prev;
  logic          force_pend;
  logic          wr_en;
  logic          rd_en;
  logic          lvl_hit;
  logic          hit;

  assign wr_en = bus.sample_valid && !abort &&
                 (state == PRE_FILL ||
                  state == WAIT_TRIG ||
                  state == POST_FILL);

  assign rd_en = !abort && state == READOUT &&
                 (!bus.out_valid || bus.out_ready) &&
                 rd_cnt != ALL_N;

  assign cnt_inc = cnt + 1'b1;
  assign busy    = state != IDLE;

  always_comb begin
    lvl_hit = 1'b0;
    if (have_prev) begin
      if (trig_slope == SLOPE_FALL)
        lvl_hit = prev > trig_level &&
                  bus.sample_in <= trig_level;
      else
        lvl_hit = prev < trig_level &&
                  bus.sample_in >= trig_level;
    end
  end

  assign hit = state == WAIT_TRIG && wr_en &&
               (lvl_hit || force_trig || force_pend);

  scope_sample_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (bus.sample_in),
    .re    (rd_en),
    .raddr (rd_ptr),
    .rdata (bus.out_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      trig_addr     <= '0;
      cnt           <= '0;
      rd_cnt        <= '0;
      prev          <= '0;
      have_prev     <= 1'b0;
      force_pend    <= 1'b0;
      triggered     <= 1'b0;
      done          <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wr_en) begin
        wr_ptr    <= wr_ptr + 1'b1;
        prev      <= bus.sample_in;
        have_prev <= 1'b1;
      end
      if (abort) begin
        state         <= IDLE;
        triggered     <= 1'b0;
        force_pend    <= 1'b0;
        bus.out_valid <= 1'b0;
        bus.out_last  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (arm) begin
            state      <= PRE_FILL;
            wr_ptr     <= '0;
            cnt        <= '0;
            rd_cnt     <= '0;
            triggered  <= 1'b0;
            have_prev  <= 1'b0;
            force_pend <= 1'b0;
          end
          PRE_FILL: if (wr_en) begin
            cnt <= cnt_inc;
            if (cnt_inc == PRE_N) begin
              state <= WAIT_TRIG;
              cnt   <= '0;
            end
          end
          WAIT_TRIG: begin
            if (force_trig) force_pend <= 1'b1;
            if (hit) begin
              trig_addr  <= wr_ptr;
              rd_ptr     <= wr_ptr - PRE_OF;
              rd_cnt     <= '0;
              triggered  <= 1'b1;
              force_pend <= 1'b0;
              cnt        <= CW'(1);
              state      <= (POST_N == CW'(1)) ?
                            READOUT : POST_FILL;
            end
          end
          POST_FILL: if (wr_en) begin
            cnt <= cnt_inc;
            if (cnt_inc == POST_N) state <= READOUT;
          end
          READOUT: begin
            // Fetch refills the output register whenever it drains.
            if (rd_en) begin
              rd_ptr        <= rd_ptr + 1'b1;
              rd_cnt        <= rd_cnt + 1'b1;
              bus.out_valid <= 1'b1;
              bus.out_last  <= rd_cnt == ALL_N - 1'b1;
            end else if (bus.out_valid && bus.out_ready) begin
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              done          <= 1'b1;
              state         <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scope_capture.sv
// Directed bench for scope_capture: ramp/constant captures,
// stalls, abort, reset, with hand-derived expected readouts.
module tb_scope_capture;

  logic       clk;
  logic       reset;
  logic       arm;
  logic       abort;
  logic       force_trig;
  logic [7:0] trig_level;
  logic       trig_slope;
  logic       busy;
  logic       triggered;
  logic       done;

  scope_capture_if bus();

  scope_capture dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .arm        (arm),
    .abort      (abort),
    .force_trig (force_trig),
    .trig_level (trig_level),
    .trig_slope (trig_slope),
    .busy       (busy),
    .triggered  (triggered),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] got [256];
  int n_xfer;
  int last_idx;
  int last_cnt;
  int done_cnt;
  int stall_err;
  int trig_seen;
  int first_x;
  int last_x;

  function automatic logic ready_pat(input int c);
    return (c % 4 == 0) || (c % 4 == 3);
  endfunction

  function automatic logic [7:0] gen(input int kind, input int k);
    if (kind == 0) return 8'(k % 256);
    return 8'd50;
  endfunction

  // Runs one full capture and records every readout transfer.
  task automatic capture(input int kind, input logic slope,
                         input logic [7:0] level,
                         input int force_at, input bit toggle);
    int k = 0;
    int cyc = 0;
    int tail = 0;
    bit forced = 0;
    bit stalled = 0;
    logic [7:0] held = 0;
    logic held_last = 0;
    n_xfer = 0; last_idx = -1; last_cnt = 0; done_cnt = 0;
    stall_err = 0; trig_seen = 0; first_x = -1; last_x = -1;
    trig_level = level;
    trig_slope = slope;
    @(negedge clk);
    arm = 1;
    @(negedge clk);
    arm = 0;
    while (tail < 4) begin
      bus.out_ready = toggle ? ready_pat(cyc) : 1'b1;
      if (k == force_at && !forced) begin
        force_trig = 1; bus.sample_valid = 0; forced = 1;
      end else begin
        force_trig = 0; bus.sample_valid = 1;
        bus.sample_in = gen(kind, k); k++;
      end
      if (stalled && (bus.out_data !== held ||
                      bus.out_last !== held_last))
        stall_err++;
      if (triggered) trig_seen = 1;
      if (done) done_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        if (n_xfer < 256) got[n_xfer] = bus.out_data;
        if (bus.out_last) begin last_cnt++; last_idx = n_xfer; end
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
        n_xfer++;
      end
      stalled = bus.out_valid && !bus.out_ready;
      held = bus.out_data;
      held_last = bus.out_last;
      if (done_cnt > 0) tail++;
      cyc++;
      if (cyc > 4000) begin
        checks++; errors++;
        $display("FAIL capture_timeout xfers=%0d required done", n_xfer);
        break;
      end
      @(negedge clk);
    end
    bus.sample_valid = 0;
    force_trig = 0;
    bus.out_ready = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 0;
    #1;
    checks++;
    if ({busy, triggered, done, bus.out_valid, bus.out_last,
         bus.out_data} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b required=0",
               {busy, triggered, done, bus.out_valid,
                bus.out_last, bus.out_data});
    end
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_busy got=%b required=0", busy);
    end
  endtask

  task automatic test_rising();
    int bad = 0;
    int fb = -1;
    capture(0, 1'b0, 8'd128, -1, 0);
    for (int i = 0; i < 256; i++)
      if (got[i] !== 8'((64 + i) % 256)) begin
        bad++; if (fb < 0) fb = i;
      end
    checks++;
    if (n_xfer !== 256) begin
      errors++; $display("FAIL rise_count got=%0d required=256", n_xfer);
    end
    checks++;
    if (got[0] !== 8'd64) begin
      errors++; $display("FAIL rise_idx0 got=%0d required=64", got[0]);
    end
    checks++;
    if (got[64] !== 8'd128) begin
      errors++; $display("FAIL rise_idx64 got=%0d required=128", got[64]);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rise_order bad=%0d first=%0d got=%0d required=%0d",
               bad, fb, got[fb], (64 + fb) % 256);
    end
    checks++;
    if (last_idx !== 255 || last_cnt !== 1) begin
      errors++;
      $display("FAIL rise_last idx=%0d cnt=%0d required idx=255 cnt=1",
               last_idx, last_cnt);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++; $display("FAIL rise_done got=%0d required=1", done_cnt);
    end
    checks++;
    if (trig_seen !== 1) begin
      errors++; $display("FAIL rise_triggered got=%0d required=1", trig_seen);
    end
    checks++;
    if (last_x - first_x !== 255) begin
      errors++;
      $display("FAIL rise_bubbles span=%0d required=255", last_x - first_x);
    end
    checks++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rise_idle busy=%b valid=%b required 0 0",
               busy, bus.out_valid);
    end
  endtask

  task automatic test_falling();
    int bad = 0;
    int fb = -1;
    capture(0, 1'b1, 8'd10, -1, 0);
    for (int i = 0; i < 256; i++)
      if (got[i] !== 8'((192 + i) % 256)) begin
        bad++; if (fb < 0) fb = i;
      end
    checks++;
    if (n_xfer !== 256) begin
      errors++; $display("FAIL fall_count got=%0d required=256", n_xfer);
    end
    checks++;
    if (got[64] !== 8'd0) begin
      errors++; $display("FAIL fall_idx64 got=%0d required=0", got[64]);
    end
    checks++;
    if (got[63] !== 8'd255) begin
      errors++; $display("FAIL fall_idx63 got=%0d required=255", got[63]);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL fall_order bad=%0d first=%0d got=%0d required=%0d",
               bad, fb, got[fb], (192 + fb) % 256);
    end
  endtask

  task automatic test_force();
    int bad = 0;
    capture(1, 1'b0, 8'd128, 100, 0);
    for (int i = 0; i < 256; i++)
      if (got[i] !== 8'd50) bad++;
    checks++;
    if (trig_seen !== 1) begin
      errors++; $display("FAIL force_triggered got=%0d required=1", trig_seen);
    end
    checks++;
    if (n_xfer !== 256 || bad != 0) begin
      errors++;
      $display("FAIL force_data xfers=%0d bad=%0d required 256 0",
               n_xfer, bad);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++; $display("FAIL force_done got=%0d required=1", done_cnt);
    end
  endtask

  task automatic test_stall();
    int bad = 0;
    capture(0, 1'b0, 8'd128, -1, 1);
    for (int i = 0; i < 256; i++)
      if (got[i] !== 8'((64 + i) % 256)) bad++;
    checks++;
    if (stall_err !== 0) begin
      errors++; $display("FAIL stall_hold got=%0d required=0", stall_err);
    end
    checks++;
    if (n_xfer !== 256 || bad != 0) begin
      errors++;
      $display("FAIL stall_order xfers=%0d bad=%0d required 256 0",
               n_xfer, bad);
    end
    checks++;
    if (last_idx !== 255 || done_cnt !== 1) begin
      errors++;
      $display("FAIL stall_last idx=%0d done=%0d required 255 1",
               last_idx, done_cnt);
    end
  endtask

  task automatic test_abort();
    int k = 0;
    int cyc = 0;
    int dn = 0;
    int bad = 0;
    trig_level = 128; trig_slope = 0; bus.out_ready = 1;
    @(negedge clk); arm = 1;
    @(negedge clk); arm = 0;
    while (!triggered && cyc < 2000) begin
      bus.sample_valid = 1; bus.sample_in = 8'(k % 256); k++;
      @(negedge clk); cyc++;
    end
    repeat (10) begin
      bus.sample_in = 8'(k % 256); k++; @(negedge clk);
    end
    checks++;
    if (triggered !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_postfill_reach trig=%b busy=%b required 1 1",
               triggered, busy);
    end
    abort = 1; bus.sample_valid = 0;
    @(negedge clk); abort = 0;
    checks++;
    if ({busy, triggered, bus.out_valid} !== 3'b000) begin
      errors++;
      $display("FAIL abort_postfill got=%b required=000",
               {busy, triggered, bus.out_valid});
    end
    @(negedge clk); arm = 1;
    @(negedge clk); arm = 0;
    k = 0; cyc = 0;
    while (!bus.out_valid && cyc < 2000) begin
      bus.sample_valid = 1; bus.sample_in = 8'(k % 256); k++;
      @(negedge clk); cyc++;
    end
    bus.sample_valid = 0;
    repeat (10) @(negedge clk);
    abort = 1;
    @(negedge clk); abort = 0;
    checks++;
    if ({busy, triggered, bus.out_valid, bus.out_last} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_readout got=%b required=0000",
               {busy, triggered, bus.out_valid, bus.out_last});
    end
    if (done) dn++;
    repeat (5) begin @(negedge clk); if (done) dn++; end
    checks++;
    if (dn !== 0) begin
      errors++; $display("FAIL abort_no_done got=%0d required=0", dn);
    end
    capture(0, 1'b0, 8'd128, -1, 0);
    for (int i = 0; i < 256; i++)
      if (got[i] !== 8'((64 + i) % 256)) bad++;
    checks++;
    if (n_xfer !== 256 || bad != 0 || done_cnt !== 1) begin
      errors++;
      $display("FAIL abort_rearm xfers=%0d bad=%0d done=%0d required 256 0 1",
               n_xfer, bad, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    trig_level = 128; trig_slope = 0;
    @(negedge clk); arm = 1;
    @(negedge clk); arm = 0;
    for (int i = 0; i < 80; i++) begin
      bus.sample_valid = 1; bus.sample_in = 8'd50;
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL midreset_busy_before got=%b required=1", busy);
    end
    reset = 0; arm = 1;
    #1;
    checks++;
    if ({busy, triggered, done, bus.out_valid, bus.out_last,
         bus.out_data} !== 13'd0) begin
      errors++;
      $display("FAIL midreset_outputs got=%b required=0",
               {busy, triggered, done, bus.out_valid,
                bus.out_last, bus.out_data});
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL midreset_arm_ignored got=%b required=0", busy);
    end
    arm = 0; bus.sample_valid = 0; reset = 1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || triggered !== 1'b0) begin
      errors++;
      $display("FAIL midreset_release busy=%b trig=%b required 0 0",
               busy, triggered);
    end
  endtask

  initial begin
    reset = 1; arm = 0; abort = 0; force_trig = 0;
    trig_level = 0; trig_slope = 0;
    bus.sample_in = 0; bus.sample_valid = 0; bus.out_ready = 1;
    test_reset();
    test_rising();
    test_falling();
    test_force();
    test_stall();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
